// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial sequence-detector stream controller:
// FSM state encoding and default width parameters.
package seq_det_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_SHIFT = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam int DEF_WORD_W = 16;
    localparam int CNT_W      = $clog2(DEF_WORD_W + 1);
    localparam int IDX_W      = $clog2(DEF_WORD_W);

endpackage

// File: rtl/seq_det_tag_pipe.sv
// Delays the {valid, index} tag of each shifted bit by the detector latency so
// that det_y can be matched to the bit that produced it.
module seq_det_tag_pipe #(
    parameter int IDX_W = seq_det_pkg::IDX_W,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             in_vld,
    input  logic [IDX_W-1:0] in_idx,
    output logic             out_vld,
    output logic [IDX_W-1:0] out_idx
);

    generate
        if (DEPTH == 0) begin : g_pass
            // Zero-latency detector: the tag of the bit on det_x is already current.
            logic unused_pins;
            assign unused_pins = clk ^ reset ^ clr;
            assign out_vld     = in_vld;
            assign out_idx     = in_idx;
        end else begin : g_pipe
            logic [IDX_W:0] stage_q [DEPTH];

            always_ff @(posedge clk) begin
                if (reset || clr) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_q[i] <= '0;
                    end
                end else begin
                    stage_q[0] <= {in_vld, in_idx};
                    for (int i = 1; i < DEPTH; i++) begin
                        stage_q[i] <= stage_q[i-1];
                    end
                end
            end

            assign {out_vld, out_idx} = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/seq_det_stream_ctrl.sv
// Streams a captured word MSB-first into a serial sequence detector and
// collects its hits into a count and the index of the first hit.
module seq_det_stream_ctrl
    import seq_det_pkg::*;
#(
    parameter int WORD_W  = DEF_WORD_W,
    parameter int DET_LAT = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        abort,
    input  logic [WORD_W-1:0]           word_in,
    output logic                        det_x,
    output logic                        det_reset,
    input  logic                        det_y,
    output logic                        busy,
    output logic                        done,
    output logic                        hit_found,
    output logic [$clog2(WORD_W+1)-1:0] hit_count,
    output logic [$clog2(WORD_W)-1:0]   first_hit_idx
);

    localparam int              CW         = $clog2(WORD_W + 1);
    localparam int              IW         = $clog2(WORD_W);
    localparam logic [CW-1:0]   BITS       = CW'(WORD_W);
    localparam logic [1:0]      DRAIN_LAST = 2'((DET_LAT > 0) ? DET_LAT - 1 : 0);

    state_e            state_q, state_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [1:0]        drain_cnt_q, drain_cnt_d;
    logic              det_x_q, det_x_d;
    logic              det_reset_q, det_reset_d;
    logic              tag_vld_q, tag_vld_d;
    logic [IW-1:0]     tag_idx_q, tag_idx_d;
    logic              hit_found_q, hit_found_d;
    logic [CW-1:0]     hit_count_q, hit_count_d;
    logic [IW-1:0]     first_idx_q, first_idx_d;
    logic              pipe_clr;
    logic              pipe_vld;
    logic [IW-1:0]     pipe_idx;

    seq_det_tag_pipe #(
        .IDX_W (IW),
        .DEPTH (DET_LAT)
    ) u_tag_pipe (
        .clk     (clk),
        .reset   (reset),
        .clr     (pipe_clr),
        .in_vld  (tag_vld_q),
        .in_idx  (tag_idx_q),
        .out_vld (pipe_vld),
        .out_idx (pipe_idx)
    );

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        drain_cnt_d = drain_cnt_q;
        det_x_d     = 1'b0;
        det_reset_d = 1'b0;
        tag_vld_d   = 1'b0;
        tag_idx_d   = tag_idx_q;
        hit_found_d = hit_found_q;
        hit_count_d = hit_count_q;
        first_idx_d = first_idx_q;
        pipe_clr    = 1'b0;

        // det_y only counts when it is the delayed answer to a bit of this run.
        if (pipe_vld && det_y && (state_q == ST_SHIFT || state_q == ST_DRAIN)) begin
            if (hit_count_q != BITS) begin
                hit_count_d = hit_count_q + 1'b1;
            end
            if (!hit_found_q) begin
                hit_found_d = 1'b1;
                first_idx_d = pipe_idx;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    shreg_d     = word_in;
                    bit_cnt_d   = '0;
                    hit_found_d = 1'b0;
                    hit_count_d = '0;
                    first_idx_d = '0;
                    det_reset_d = 1'b1;
                    pipe_clr    = 1'b1;
                    state_d     = ST_CLR;
                end
            end
            ST_CLR, ST_SHIFT: begin
                if (bit_cnt_q == BITS) begin
                    drain_cnt_d = '0;
                    state_d     = (DET_LAT == 0) ? ST_DONE : ST_DRAIN;
                end else begin
                    det_x_d   = shreg_q[WORD_W-1];
                    shreg_d   = {shreg_q[WORD_W-2:0], 1'b0};
                    tag_vld_d = 1'b1;
                    tag_idx_d = bit_cnt_q[IW-1:0];
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    state_d   = ST_SHIFT;
                end
            end
            ST_DRAIN: begin
                drain_cnt_d = drain_cnt_q + 2'd1;
                if (drain_cnt_q == DRAIN_LAST) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort) begin
            state_d     = ST_IDLE;
            det_x_d     = 1'b0;
            det_reset_d = 1'b0;
            tag_vld_d   = 1'b0;
            hit_found_d = 1'b0;
            hit_count_d = '0;
            first_idx_d = '0;
            pipe_clr    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            drain_cnt_q <= '0;
            det_x_q     <= 1'b0;
            det_reset_q <= 1'b0;
            tag_vld_q   <= 1'b0;
            tag_idx_q   <= '0;
            hit_found_q <= 1'b0;
            hit_count_q <= '0;
            first_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            det_x_q     <= det_x_d;
            det_reset_q <= det_reset_d;
            tag_vld_q   <= tag_vld_d;
            tag_idx_q   <= tag_idx_d;
            hit_found_q <= hit_found_d;
            hit_count_q <= hit_count_d;
            first_idx_q <= first_idx_d;
        end
    end

    assign det_x         = det_x_q;
    assign det_reset     = det_reset_q;
    assign busy          = (state_q != ST_IDLE);
    assign done          = (state_q == ST_DONE);
    assign hit_found     = hit_found_q;
    assign hit_count     = hit_count_q;
    assign first_hit_idx = first_idx_q;

endmodule

// File: tb/tb_seq_det_stream_ctrl.sv
// Bench for seq_det_stream_ctrl: three builds (DET_LAT 1, 0, 3) share one
// stimulus stream, each driving its own "1011" detector model and scoreboard.
module tb_seq_det_stream_ctrl;

    localparam int W  = 16;
    localparam int CW = $clog2(W + 1);
    localparam int IW = $clog2(W);

    typedef struct packed {
        logic [31:0]   edge_n;
        logic          found;
        logic [IW-1:0] first;
        logic [CW-1:0] cnt;
    } exp_t;

    logic         clk     = 1'b0;
    logic         reset   = 1'b1;
    logic         start   = 1'b0;
    logic         abort   = 1'b0;
    logic [W-1:0] word_in = '0;

    int n_checks = 0;
    int n_fail   = 0;
    bit model_run [3];

    // clock / reset
    always #5 clk = ~clk;

    // Expected result of one complete run: hit at bit j when bits j-3..j read 1011.
    function automatic exp_t ref_run(input logic [W-1:0] w, input int unsigned de);
        exp_t         r;
        logic [W-1:0] b;
        r        = '0;
        r.edge_n = de;
        for (int j = 0; j < W; j++) b[j] = w[W-1-j];
        for (int j = 3; j < W; j++) begin
            if (b[j-3] && !b[j-2] && b[j-1] && b[j]) begin
                if (!r.found) begin
                    r.found = 1'b1;
                    r.first = IW'(j);
                end
                r.cnt = r.cnt + 1'b1;
            end
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    generate
        for (genvar g = 0; g < 3; g++) begin : g_inst
            localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 0 : 3);

            logic          det_x, det_reset, det_y, busy, done, hit_found;
            logic [CW-1:0] hit_count;
            logic [IW-1:0] first_hit_idx;

            seq_det_stream_ctrl #(
                .WORD_W  (W),
                .DET_LAT (LAT)
            ) dut (
                .clk           (clk),
                .reset         (reset),
                .start         (start),
                .abort         (abort),
                .word_in       (word_in),
                .det_x         (det_x),
                .det_reset     (det_reset),
                .det_y         (det_y),
                .busy          (busy),
                .done          (done),
                .hit_found     (hit_found),
                .hit_count     (hit_count),
                .first_hit_idx (first_hit_idx)
            );

            // Overlapping "1011" detector, answer delayed LAT clocks.
            logic [2:0] hist_q = '0;
            logic [3:0] ypipe_q = '0;
            logic       m;
            logic [4:0] yv;
            assign m     = ({hist_q, det_x} == 4'b1011);
            assign yv    = {ypipe_q, m};
            assign det_y = yv[LAT];

            always @(posedge clk) begin
                if (det_reset) begin
                    hist_q  <= '0;
                    ypipe_q <= '0;
                end else begin
                    hist_q  <= {hist_q[1:0], det_x};
                    ypipe_q <= {ypipe_q[2:0], m};
                end
            end

            // Reference model: tracks runs by edge number, pushes expected done.
            int unsigned e  = 0;
            int unsigned e0 = 0;
            bit          run = 1'b0;
            logic [W-1:0] word_m = '0;
            exp_t        res = '0;
            exp_t        fin = '0;
            exp_t        exp_q[$];

            initial forever begin
                @(posedge clk);
                e++;
                if (reset) begin
                    run = 1'b0;
                    res = '0;
                    exp_q.delete();
                end else if (abort) begin
                    run = 1'b0;
                    res = '0;
                    exp_q.delete();
                end else if (run) begin
                    if (e == e0 + W + LAT + 1) res = fin;
                    if (e == e0 + W + LAT + 2) run = 1'b0;
                end else if (start) begin
                    e0     = e;
                    word_m = word_in;
                    fin    = ref_run(word_in, e0 + W + LAT + 1);
                    exp_q.push_back(fin);
                    res    = '0;
                    run    = 1'b1;
                end
                model_run[g] = run;
            end

            // Monitor / scoreboard
            initial forever begin
                logic exp_x;
                exp_t h;
                @(negedge clk);
                exp_x = 1'b0;
                if (run && e > e0 && e <= e0 + W) exp_x = word_m[W-1-int'(e-e0-1)];
                check($sformatf("L%0d det_x", LAT), 64'(det_x), 64'(exp_x));
                check($sformatf("L%0d det_reset", LAT), 64'(det_reset), 64'(run && e == e0));
                check($sformatf("L%0d busy", LAT), 64'(busy), 64'(run));
                if (done === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        check($sformatf("L%0d unexpected done", LAT), 64'(done), 64'(0));
                    end else begin
                        h = exp_q.pop_front();
                        check($sformatf("L%0d done edge", LAT), 64'(e), 64'(h.edge_n));
                        check($sformatf("L%0d hit_count", LAT), 64'(hit_count), 64'(h.cnt));
                        check($sformatf("L%0d first_hit_idx", LAT), 64'(first_hit_idx), 64'(h.first));
                        check($sformatf("L%0d hit_found", LAT), 64'(hit_found), 64'(h.found));
                    end
                end else if (exp_q.size() > 0 && exp_q[0].edge_n == e) begin
                    check($sformatf("L%0d done missing", LAT), 64'(done), 64'(1));
                    void'(exp_q.pop_front());
                end
                if (!run) begin
                    check($sformatf("L%0d held hit_count", LAT), 64'(hit_count), 64'(res.cnt));
                    check($sformatf("L%0d held first_hit_idx", LAT), 64'(first_hit_idx), 64'(res.first));
                    check($sformatf("L%0d held hit_found", LAT), 64'(hit_found), 64'(res.found));
                end
            end
        end
    endgenerate

    // driver tasks
    task automatic start_word(input logic [W-1:0] w);
        @(negedge clk);
        start   = 1'b1;
        word_in = w;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (!model_run[0] && !model_run[1] && !model_run[2]) return;
        end
        n_checks++;
        n_fail++;
        $display("FAIL wait_idle: still busy after 64 cycles, required idle");
    endtask

    task automatic pulse_abort_after(input int d);
        repeat (d) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    task automatic pulse_reset_after(input int d);
        repeat (d) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        start_word(16'b0001011010001110); wait_idle();
        start_word(16'hBBBB);             wait_idle();
        start_word(16'hFFFF);             wait_idle();

        // start repeated during SHIFT is ignored
        start_word(16'b0001011010001110);
        repeat (3) @(negedge clk);
        start   = 1'b1;
        word_in = 16'hBBBB;
        repeat (5) @(negedge clk);
        start   = 1'b0;
        wait_idle();

        // abort in SHIFT cycle 5, then a clean run
        start_word(16'hBBBB);
        pulse_abort_after(6);
        wait_idle();
        start_word(16'hBBBB); wait_idle();

        // reset in SHIFT cycle 5, then a clean run
        start_word(16'hBBBB);
        pulse_reset_after(6);
        wait_idle();
        start_word(16'b0001011010001110); wait_idle();

        // abort together with start in IDLE: abort wins
        pulse_reset_after(0);
        @(negedge clk);
        start   = 1'b1;
        abort   = 1'b1;
        word_in = 16'hBBBB;
        @(negedge clk);
        start   = 1'b0;
        abort   = 1'b0;
        repeat (3) @(negedge clk);

        // start held high: runs back to back, start in DONE ignored
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < 45; i++) begin
            word_in = W'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        wait_idle();

        // randomized runs
        for (int it = 0; it < 24; it++) begin
            int mode;
            mode = $urandom_range(0, 3);
            start_word(W'($urandom));
            case (mode)
                1: pulse_abort_after($urandom_range(0, W));
                2: begin
                    repeat ($urandom_range(1, 6)) @(negedge clk);
                    start   = 1'b1;
                    word_in = W'($urandom);
                    @(negedge clk);
                    start   = 1'b0;
                end
                3: pulse_reset_after($urandom_range(0, W + 4));
                default: ;
            endcase
            wait_idle();
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        wait_idle();
        repeat (3) @(negedge clk);
        check("L1 pending expectations", 64'(g_inst[0].exp_q.size()), 64'(0));
        check("L0 pending expectations", 64'(g_inst[1].exp_q.size()), 64'(0));
        check("L3 pending expectations", 64'(g_inst[2].exp_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
